uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver.
//  - Configurable data width, parity and stop bits; 3-sample majority vote per bit.
//  - False-start rejection; per-word parity/framing error flags.
//  - Output FIFO with valid/ready handshake and overrun flag.
//  Sits between the board rx pin and the challenge/response datapath.
// PARAMETERS
//  DATA_BITS         8       data bits per frame, 5..16, LSB first
//  frequency_clk_ref 100     clk frequency in MHz
//  BAUD_RATE         115200  serial baud rate
//  PARITY            0       0 none, 1 odd, 2 even
//  STOP_BITS         1       1 or 2
//  FIFO_DEPTH        4       output FIFO words, power of 2, >=2
// PORTS
//  clk            in   1          clock
//  n_reset        in   1          asynchronous reset, active low
//  rx_pin         in   1          serial input, idle high, asynchronous
//  rx_data        out  DATA_BITS  head-of-FIFO data
//  rx_parity_err  out  1          head word parity error (0 when PARITY=0)
//  rx_frame_err   out  1          head word stop-bit error
//  rx_data_valid  out  1          FIFO not empty
//  rx_data_ready  in   1          consumer accepts head word this cycle
//  rx_overrun     out  1          1-cycle pulse: completed word dropped, FIFO full
//  rx_busy        out  1          FSM not in S_IDLE
// BEHAVIOUR
//  - CYCLE = frequency_clk_ref*1000000/BAUD_RATE clocks per bit; HALF = CYCLE/2.
//  - rx_pin passes a 2-FF synchroniser; both FFs reset to 1, so no spurious edge after reset.
//  - Reset: all outputs 0, FSM S_IDLE, FIFO empty, counters 0.
//  - Majority sample = majority of synced line at cycle_cnt HALF-2, HALF-1, HALF.
//  - FSM states and transitions:
//    - S_IDLE: synced falling edge -> S_START, cycle_cnt=0.
//    - S_START: at sample point, majority 1 -> S_IDLE (false start, nothing pushed).
//      Else at cycle_cnt==CYCLE-1 -> S_DATA, bit_cnt=0.
//    - S_DATA: shift majority into bit bit_cnt; after DATA_BITS bits -> S_PARITY if PARITY!=0, else S_STOP.
//    - S_PARITY: parity_err = (XOR data ^ sampled bit) != (PARITY==1).
//      Odd: data plus parity bit has odd count of 1s.
//    - S_STOP: sample each stop bit; any 0 sets frame_err.
//      At the last stop bit's sample point push {frame_err,parity_err,data} into the FIFO,
//      then -> S_IDLE; if the line is low (break) -> S_BREAK instead.
//      Leaving at mid-stop allows back-to-back frames.
//    - S_BREAK: wait for synced line high, then -> S_IDLE.
//  - cycle_cnt counts 0..CYCLE-1 per bit and wraps to 0 at each bit boundary.
//  - Latency: rx_data_valid rises 1 clk after the last stop-bit sample point.
//  - FIFO, first-word-fall-through:
//    - Pop when rx_data_valid & rx_data_ready.
//    - Push when full without a pop: word dropped, rx_overrun high 1 clk, FIFO contents unchanged.
//    - Push and pop in the same cycle are both honoured, including when full (count unchanged).
//    - rx_data and error flags are held stable while valid & !ready.
//  - Async reset mid-frame aborts the frame; no partial word is ever pushed.
// STRUCTURE
//  - Package uart_pkg:
//    - PARITY_NONE/ODD/EVEN localparams.
//    - FSM state encodings (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK).
//    - Function calc_cycle(freq_mhz, baud).
//  - Sub-module uart_rx_fifo #(WIDTH, DEPTH):
//    - Synchronous FWFT FIFO, ptrs one bit wider than log2(DEPTH), full/empty outputs.
//  - Top holds synchroniser, FSM, counters, shift register, majority logic.
// TESTING  (bench: frequency_clk_ref=16, BAUD_RATE=1000000 -> CYCLE=16)
//  - 8N1, send 0xA5, ready=1 -> valid for 1 clk, rx_data=0xA5, both err flags 0.
//  - PARITY=2, send 0x07 with parity bit 0 -> rx_data=0x07, rx_parity_err=1.
//    Repeat with parity bit 1 -> rx_parity_err=0.
//  - 8N1, 0x3C with stop bit low -> rx_frame_err=1.
//    Line held low 3 bit times -> rx_busy stays 1 until line high, then exactly one word.
//  - Glitch low for 4 clks on idle line -> no push; rx_busy back to 0 by cycle HALF+3.
//    1-clk glitch mid data bit -> majority keeps correct value.
//  - FIFO_DEPTH=4, ready=0, send 5 frames 0x01..0x05 -> overrun pulse on 5th.
//    Then ready=1 -> 0x01..0x04 in order, valid drops after 4th.
//  - Assert n_reset low mid-S_DATA, release, send 0x5A -> only 0x5A received.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and timing helper for the UART receiver
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic int calc_cycle(input int freq_mhz, input int baud);
    return (freq_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through FIFO holding received words
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is still taken.
  assign do_push = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority sampling and output FIFO
module uart_rx_param #(
  parameter int DATA_BITS         = 8,
  parameter int frequency_clk_ref = 100,
  parameter int BAUD_RATE         = 115200,
  parameter int PARITY            = 0,
  parameter int STOP_BITS         = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  import uart_pkg::*;

  localparam int CYCLE = calc_cycle(frequency_clk_ref, BAUD_RATE);
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = $clog2(CYCLE + 1);
  localparam int BW    = 5;
  localparam logic [CW-1:0] C_LAST   = CW'(CYCLE - 1);
  localparam logic [CW-1:0] C_V0     = CW'(HALF - 2);
  localparam logic [CW-1:0] C_V1     = CW'(HALF - 1);
  localparam logic [CW-1:0] C_SAMPLE = CW'(HALF);

  state_t               state, state_next;
  logic                 sync1, sync2, sync3;
  logic [CW-1:0]        cycle_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           votes;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_err, frame_err;
  logic                 fall, sample_pt, bit_end, maj, push, pop, fifo_full, fifo_empty;

  // Third flop only remembers the previous synced level for edge detection.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) {sync1, sync2, sync3} <= 3'b111;
    else          {sync1, sync2, sync3} <= {rx_pin, sync1, sync2};
  end

  assign fall      = sync3 & ~sync2;
  assign sample_pt = (cycle_cnt == C_SAMPLE);
  assign bit_end   = (cycle_cnt == C_LAST);
  assign maj       = (votes[0] & votes[1]) | (votes[0] & sync2) | (votes[1] & sync2);
  assign rx_busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_next = S_START;
      S_START:  if (sample_pt && maj) state_next = S_IDLE;
                else if (bit_end)     state_next = S_DATA;
      S_DATA:   if (bit_end && bit_cnt == BW'(DATA_BITS - 1))
                  state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (sample_pt && bit_cnt == BW'(STOP_BITS - 1)) begin
                  push       = 1'b1;
                  state_next = maj ? S_IDLE : S_BREAK;
                end
      S_BREAK:  if (sync2) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
      votes      <= '0;
      shift      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == S_IDLE || state_next == S_IDLE || state_next == S_BREAK) cycle_cnt <= '0;
      else cycle_cnt <= bit_end ? '0 : cycle_cnt + 1'b1;

      if (state != state_next) bit_cnt <= '0;
      else if (bit_end && (state == S_DATA || state == S_STOP)) bit_cnt <= bit_cnt + 1'b1;

      if (cycle_cnt == C_V0) votes[0] <= sync2;
      if (cycle_cnt == C_V1) votes[1] <= sync2;

      if (state == S_IDLE && fall) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (state == S_DATA && sample_pt) shift <= {maj, shift[DATA_BITS-1:1]};
      if (state == S_PARITY && sample_pt)
        parity_err <= ((^shift) ^ maj) != (PARITY == PARITY_ODD);
      if (state == S_STOP && sample_pt && !maj) frame_err <= 1'b1;
    end
  end

  assign pop = rx_data_valid & rx_data_ready;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push),
    .push_data ({frame_err | ~maj, parity_err, shift}),
    .pop       (pop),
    .pop_data  ({rx_frame_err, rx_parity_err, rx_data}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_data_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rx_overrun <= 1'b0;
    else          rx_overrun <= push & fifo_full & ~pop;
  end

endmodule
